// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle pool.
//   slot_state_e    : per-slot occupancy state (IDLE / ACTIVE)
//   FP_SHIFT        : number of fractional bits in internal positions
//   pos_t / pix_t   : 18-bit fixed-point position and 11-bit pixel coordinate
//   step_from_speed : per-frame fixed-point X step for a speed select
//   to_pix          : fixed-point to pixel conversion (arithmetic shift)
package obstacle_pkg;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_ACTIVE = 1'b1
  } slot_state_e;

  localparam int FP_SHIFT = 6;
  localparam int POS_W    = 18;
  localparam int PIX_W    = 11;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [PIX_W-1:0] pix_t;

  // Step grows linearly with speed: speed 0 moves one base step per frame.
  function automatic pos_t step_from_speed(input logic [1:0] speed, input int step_base);
    int mult_v;
    mult_v = int'(speed) + 32'sd1;
    return pos_t'(step_base * mult_v);
  endfunction

  // Arithmetic shift rounds toward minus infinity, so -0.5 px reads as -1,
  // which keeps the sprite edge consistent while crossing the left border.
  function automatic pix_t to_pix(input pos_t p);
    pos_t shifted_v;
    shifted_v = p >>> FP_SHIFT;
    return shifted_v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/obstacle_pool_if.sv
// Bus bundle between the game logic and the obstacle pool.
//   master : drives frame/deploy/random/speed/collision/clear, reads results
//   slave  : the pool; drives per-slot positions, occupancy, deployAck, poolFull
interface obstacle_pool_if #(
  parameter int NUM_OBJ = 4
);

  logic                   startOfFrame;
  logic                   deploy;
  logic [7:0]             random;
  logic [1:0]             speed;
  logic [NUM_OBJ-1:0]     collision;
  logic                   clear;
  obstacle_pkg::pix_t     topLeftX [NUM_OBJ];
  obstacle_pkg::pix_t     topLeftY [NUM_OBJ];
  logic [NUM_OBJ-1:0]     active;
  logic                   deployAck;
  logic                   poolFull;

  modport master (
    output startOfFrame, deploy, random, speed, collision, clear,
    input  topLeftX, topLeftY, active, deployAck, poolFull
  );

  modport slave (
    input  startOfFrame, deploy, random, speed, collision, clear,
    output topLeftX, topLeftY, active, deployAck, poolFull
  );

endinterface

// File: rtl/obstacle_slot.sv
// One tracked obstacle: occupancy state, fixed-point position and retire logic.
//   clk, resetN   : clock, asynchronous active-low reset
//   clear_i       : synchronous retire (highest priority)
//   collision_i   : retire on hit
//   alloc_i       : load spawn position and go ACTIVE (only raised while IDLE)
//   frame_i       : apply one movement step
//   step_i        : fixed-point step for this frame
//   spawn_x_i/y_i : fixed-point spawn position
//   active_o      : slot occupied
//   x_pix_o/y_pix_o : pixel position, parked when IDLE
module obstacle_slot
  import obstacle_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int IMAGE_WIDTH   = 32
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear_i,
  input  logic collision_i,
  input  logic alloc_i,
  input  logic frame_i,
  input  pos_t step_i,
  input  pos_t spawn_x_i,
  input  pos_t spawn_y_i,
  output logic active_o,
  output pix_t x_pix_o,
  output pix_t y_pix_o
);

  localparam pos_t PARK_X   = pos_t'(SCREEN_WIDTH << FP_SHIFT);
  localparam pos_t PARK_Y   = pos_t'(SCREEN_HEIGHT << FP_SHIFT);
  // A slot is gone once its left edge is a full sprite width past x = 0.
  localparam pos_t RETIRE_X = pos_t'(-(IMAGE_WIDTH << FP_SHIFT));

  slot_state_e state_q, state_d;
  pos_t        x_q, x_d;
  pos_t        y_q, y_d;
  pos_t        moved_x_s;

  // Next state: clear > collision > allocation > movement.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    moved_x_s = x_q - step_i;
    if (clear_i || collision_i) begin
      state_d = SLOT_IDLE;
      x_d     = PARK_X;
      y_d     = PARK_Y;
    end else if (alloc_i) begin
      state_d = SLOT_ACTIVE;
      x_d     = spawn_x_i;
      y_d     = spawn_y_i;
    end else if (frame_i && (state_q == SLOT_ACTIVE)) begin
      if (moved_x_s < RETIRE_X) begin
        state_d = SLOT_IDLE;
        x_d     = PARK_X;
        y_d     = PARK_Y;
      end else begin
        x_d     = moved_x_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and position registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= SLOT_IDLE;
      x_q     <= PARK_X;
      y_q     <= PARK_Y;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign active_o = (state_q == SLOT_ACTIVE);
  assign x_pix_o  = active_o ? to_pix(x_q) : pix_t'(SCREEN_WIDTH);
  assign y_pix_o  = active_o ? to_pix(y_q) : pix_t'(SCREEN_HEIGHT);

endmodule

// File: rtl/obstacle_pool.sv
// Pool of NUM_OBJ scrolling obstacles with a lowest-index-first allocator.
//   clk, resetN : clock, asynchronous active-low reset
//   bus (slave) : frame/deploy/random/speed/collision/clear in;
//                 topLeftX/topLeftY/active/deployAck/poolFull out
module obstacle_pool
  import obstacle_pkg::*;
#(
  parameter int NUM_OBJ       = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int INITIAL_Y     = 185,
  parameter int IMAGE_WIDTH   = 32,
  parameter int STEP_BASE     = 64
) (
  input  logic            clk,
  input  logic            resetN,
  obstacle_pool_if.slave  bus
);

  logic [NUM_OBJ-1:0] active_s;
  logic [NUM_OBJ-1:0] free_first_s;
  logic [NUM_OBJ-1:0] alloc_s;
  logic               found_s;
  logic               ack_d, ack_q;
  pos_t               step_s;
  pos_t               spawn_x_s;
  pos_t               spawn_y_s;
  pix_t               x_pix_s [NUM_OBJ];
  pix_t               y_pix_s [NUM_OBJ];

  assign step_s    = step_from_speed(bus.speed, STEP_BASE);
  assign spawn_x_s = pos_t'((SCREEN_WIDTH + int'(bus.random[5:0])) << FP_SHIFT);
  assign spawn_y_s = pos_t'((INITIAL_Y + int'(bus.random[7:6]) * 8) << FP_SHIFT);

  // Priority encoder over the IDLE set as registered at the start of the
  // cycle, so a slot freed by this cycle's collision is not reused yet.
  always_comb begin
    free_first_s = '0;
    found_s      = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!active_s[i] && !found_s) begin
        free_first_s[i] = 1'b1;
        found_s         = 1'b1;
      end else begin
        free_first_s[i] = 1'b0;
      end
    end
  end

  // Gate the allocation with deploy and decide whether it will stick; clear or
  // a collision on the chosen slot override it, so no acknowledge is given.
  always_comb begin
    alloc_s = '0;
    ack_d   = 1'b0;
    if (bus.deploy && found_s) begin
      alloc_s = free_first_s;
      ack_d   = !bus.clear && !(|(free_first_s & bus.collision));
    end else begin
      alloc_s = '0;
      ack_d   = 1'b0;
    end
  end

  // deployAck coincides with the first cycle the new slot reads active.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
    obstacle_slot #(
      .SCREEN_WIDTH  (SCREEN_WIDTH),
      .SCREEN_HEIGHT (SCREEN_HEIGHT),
      .IMAGE_WIDTH   (IMAGE_WIDTH)
    ) u_slot (
      .clk         (clk),
      .resetN      (resetN),
      .clear_i     (bus.clear),
      .collision_i (bus.collision[g]),
      .alloc_i     (alloc_s[g]),
      .frame_i     (bus.startOfFrame),
      .step_i      (step_s),
      .spawn_x_i   (spawn_x_s),
      .spawn_y_i   (spawn_y_s),
      .active_o    (active_s[g]),
      .x_pix_o     (x_pix_s[g]),
      .y_pix_o     (y_pix_s[g])
    );
    assign bus.topLeftX[g] = x_pix_s[g];
    assign bus.topLeftY[g] = y_pix_s[g];
  end

  assign bus.active    = active_s;
  assign bus.deployAck = ack_q;
  assign bus.poolFull  = &active_s;

endmodule

// File: doc/obstacle_pool.md
OBSTACLE_POOL -- requirements
Module: obstacle_pool

Interface
REQ-001 Parameter NUM_OBJ, default 4: number of independently tracked obstacle slots (1..8).
REQ-002 Parameter SCREEN_WIDTH, default 640: parking X for inactive slots and base spawn X, in pixels.
REQ-003 Parameter SCREEN_HEIGHT, default 480: parking Y for inactive slots, in pixels.
REQ-004 Parameter INITIAL_Y, default 185: base spawn Y, in pixels.
REQ-005 Parameter IMAGE_WIDTH, default 32: sprite width; a slot retires once fully off the left edge.
REQ-006 Parameter STEP_BASE, default 64: per-frame fixed-point X step at speed 0.
REQ-007 Port clk, input, 1: system clock; single clock domain.
REQ-008 Port resetN, input, 1: asynchronous active-low reset.
REQ-009 Port startOfFrame, input, 1: one-cycle pulse per video frame (30 Hz).
REQ-010 Port deploy, input, 1: one-cycle request to spawn one obstacle.
REQ-011 Port random, input, 8: random value sampled on the deploy cycle.
REQ-012 Port speed, input, 2: scroll speed select, sampled on each startOfFrame.
REQ-013 Port collision, input, NUM_OBJ: per-slot hit, 1 = retire that slot.
REQ-014 Port clear, input, 1: synchronous retire-all.
REQ-015 Port topLeftX, output, NUM_OBJ x 11 signed: per-slot pixel X.
REQ-016 Port topLeftY, output, NUM_OBJ x 11 signed: per-slot pixel Y.
REQ-017 Port active, output, NUM_OBJ: per-slot occupancy.
REQ-018 Port deployAck, output, 1: one-cycle pulse when a deploy was accepted.
REQ-019 Port poolFull, output, 1: all slots active.

Function
REQ-020 Fixed point: internal positions SHALL be 18-bit signed with 6 fractional bits (x64); pixel outputs SHALL be an arithmetic right shift by 6, never truncating division toward zero.
REQ-021 Slot states SHALL be IDLE and ACTIVE; IDLE->ACTIVE on allocation, ACTIVE->IDLE on retire.
REQ-022 On deploy with at least one IDLE slot, the lowest-index IDLE slot SHALL become ACTIVE on the next clock edge, with X = (SCREEN_WIDTH + random[5:0]) x 64 and Y = (INITIAL_Y + random[7:6] x 8) x 64.
REQ-023 deployAck SHALL be high for exactly the cycle in which the new slot first reads active = 1.
REQ-024 A deploy when poolFull = 1 SHALL be dropped: no state change and no deployAck.
REQ-025 On startOfFrame, every ACTIVE slot not being allocated that cycle SHALL decrement X by STEP_BASE x (speed + 1); Y is unchanged.
REQ-026 On startOfFrame, an ACTIVE slot whose post-step X is below -IMAGE_WIDTH x 64 SHALL retire on that same edge.
REQ-027 collision[i] = 1 SHALL retire slot i on the next edge, regardless of startOfFrame.
REQ-028 Priority per slot SHALL be clear > collision > allocation > movement.
REQ-029 A slot allocated on a startOfFrame cycle SHALL take its spawn position unstepped.
REQ-030 A slot retired by collision on a deploy cycle SHALL NOT be reallocated in that same cycle; allocation SHALL use the IDLE set at the start of the cycle.
REQ-031 IDLE slots SHALL output topLeftX = SCREEN_WIDTH and topLeftY = SCREEN_HEIGHT.
REQ-032 poolFull SHALL be combinational AND of active; all other outputs SHALL be decoded from registers only.

Reset
REQ-033 Asserting resetN low SHALL immediately set all slots IDLE, deployAck = 0, and park all positions; this holds even during a deploy or a frame step.

Structure
REQ-034 A shared package obstacle_pkg SHALL hold the slot state enum, the FP_SHIFT = 6 constant, the 18-bit position type and the step-from-speed function.
REQ-035 One sub-module, obstacle_slot (per-slot position registers, state and retire logic), SHALL be instantiated NUM_OBJ times; the top level SHALL hold the priority-encoder allocator and deployAck.

Verification
REQ-036 Reset, then deploy with random = 8'hC5 -> slot 0 active at X = 645, Y = 209; deployAck one cycle; all other slots parked at (640, 480).
REQ-037 Slot 0 at X = 645, speed = 3, 10 startOfFrame pulses -> X = 605; speed = 0, one further pulse -> X = 604.
REQ-038 Four deploys with NUM_OBJ = 4 -> poolFull = 1; a fifth deploy -> no deployAck, state unchanged.
REQ-039 Full pool, collision = 4'b0100 together with deploy -> slot 2 IDLE next cycle, deploy dropped; a deploy on the next cycle reallocates slot 2.
REQ-040 Slot at X = -31, speed = 0, one startOfFrame -> X = -32, still active; next startOfFrame -> retired, outputs (640, 480).
REQ-041 resetN pulsed low mid-frame with 3 active slots -> active = 0 asynchronously; no deployAck after release.
